mmio_uart_tx: RTL
=================

// Module: mmio_uart_tx
// PURPOSE
//  Memory-mapped UART transmitter on the single-cycle core's data-memory port, beside data RAM.
//  Decodes core store/load traffic in a 16-byte window.
//  Queues written bytes in a small FIFO and serialises them 8N1 on a tx pin.
//  Gives the core console output without stalling it. Reads are combinational so single-cycle loads work.
// PARAMETERS
//  BASE_ADDR    32'h1000_0000  window base; decode = mem_address[31:4] == BASE_ADDR[31:4]
//  FIFO_DEPTH   8              byte FIFO entries, power of 2, >= 2
//  DEFAULT_DIV  16'd868        clocks per bit after reset (100 MHz / 115200)
// PORTS
//  clk              in   1   rising-edge clock
//  rst              in   1   synchronous, active-low reset (0 = reset, sampled on clk)
//  mem_write        in   1   core store strobe
//  mem_read         in   1   core load strobe
//  mem_address      in   32  core byte address (ALU result)
//  mem_data_to_mem  in   32  core store data (rs2)
//  uart_sel         out  1   combinational: address in window; SoC mux uses it to steer read data
//  uart_rdata       out  32  combinational read data; 0 when not selected or mem_read low
//  tx               out  1   serial line, idle high
// BEHAVIOUR
//  Register map, word offsets mem_address[3:2]; mem_address[1:0] ignored:
//   0x0 TXDATA  W: push data[7:0]; R: 0
//   0x4 STATUS  R: {28'b0, overrun, busy, empty, full}; W: any write clears overrun
//   0x8 BAUDDIV R/W: [15:0]; upper bits write-ignored, read 0
//   0xC rsvd    R: 0; W: ignored
//  Writes act on the clk edge where mem_write & uart_sel.
//  Reads are pure combinational from current state; no read side effects.
//  Reset (rst=0 at edge), all outputs/state:
//   tx=1; FIFO empty; overrun=0; BAUDDIV=DEFAULT_DIV; FSM=IDLE; counters=0.
//   Reset mid-frame aborts the frame; tx is 1 from the next edge.
//  FIFO push:
//   Write to TXDATA while not full -> enqueue.
//   Write while full -> byte dropped, overrun<=1 (sticky).
//   full/empty are judged from the start-of-cycle count.
//   Push and pop in the same cycle when full: push still drops; count stays FIFO_DEPTH-1.
//  FSM IDLE/START/DATA/STOP; bit_cnt 3b; baud_cnt 16b:
//   IDLE: tx=1. If !empty: pop head into shift reg, latch div_eff = (BAUDDIV==0)?1:BAUDDIV, go START.
//   START: tx=0 for div_eff clocks -> DATA.
//   DATA: tx=shift[0], LSB first, div_eff clocks per bit, 8 bits -> STOP.
//   STOP: tx=1 for div_eff clocks. Then pop next byte directly to START if !empty, else IDLE.
//    No extra idle cycle between back-to-back frames.
//  Frame = 10*div_eff clocks. First start bit appears on the edge after the IDLE pop:
//   2 edges after the push edge.
//  BAUDDIV write mid-frame takes effect at the next frame (div_eff latched at pop).
//  busy = (state != IDLE).
//  Push into an empty FIFO and pop happen on separate cycles; no bypass path.
//  Pointers wrap modulo FIFO_DEPTH; count is log2(FIFO_DEPTH)+1 bits.
// STRUCTURE
//  Shared package uart_pkg:
//   register offsets (UART_TXDATA=2'd0, UART_STATUS=2'd1, UART_BAUDDIV=2'd2)
//   FSM state encoding (2-bit, IDLE=0 START=1 DATA=2 STOP=3)
//   STATUS bit indices
//  Sub-module sync_fifo #(WIDTH=8, DEPTH):
//   push/pop/full/empty/dout, synchronous active-low rst.
//   Reusable later for a UART RX block.
//  Top level: address decode, register file, tx FSM.
// TESTING  (bench uses BAUDDIV=4 unless stated)
//  1 Reset: hold rst=0 3 clocks -> tx=1, STATUS=0x2, BAUDDIV reads 868, uart_rdata=0 with mem_read=0.
//  2 Single byte: store 0x55 to BASE+0 -> start bit on edge 2 after push.
//    Line then 0,1,0,1,0,1,0,1,0,1 (start, LSB-first data, stop), each held 4 clocks; STATUS busy then 0x2.
//  3 Back-to-back: push 0xA5,0x3C -> 20*4=80 clocks of frames with no idle gap; decoded bytes match order.
//  4 Overflow: BAUDDIV=1000; push 10 bytes fast -> first 9 accepted (1 popped + 8 queued).
//    10th dropped; STATUS=0x9|busy=0xD; write STATUS -> overrun clears.
//  5 Decode: store to BASE+0x10 and 0x0FFF_FFFC -> no FIFO change, uart_sel=0.
//    Load BASE+0xC -> 0; BAUDDIV write 0 -> frames at 1 clock/bit.
//  6 Reset mid-frame: assert rst during DATA bit 3 -> tx=1 next edge, FIFO empty.
//    New push after release transmits cleanly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART: register offsets,
// transmitter state encoding, STATUS bit positions and a divisor helper.
package uart_pkg;

  // Word offsets inside the 16-byte window (mem_address[3:2])
  localparam logic [1:0] UART_TXDATA  = 2'd0;
  localparam logic [1:0] UART_STATUS  = 2'd1;
  localparam logic [1:0] UART_BAUDDIV = 2'd2;
  localparam logic [1:0] UART_RSVD    = 2'd3;

  // Transmitter states
  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  // STATUS register bit positions
  localparam int STAT_FULL    = 0;
  localparam int STAT_EMPTY   = 1;
  localparam int STAT_BUSY    = 2;
  localparam int STAT_OVERRUN = 3;

  // A programmed divisor of zero would never finish a bit, so it runs as one
  // clock per bit instead.
  function automatic logic [15:0] effDiv(input logic [15:0] div);
    return (div == 16'd0) ? 16'd1 : div;
  endfunction

endpackage

// File: rtl/mmio_uart_tx_sync_fifo.sv
// Small synchronous FIFO with start-of-cycle full/empty flags. A push while
// full is dropped even if a pop happens in the same cycle; a push into an
// empty FIFO only becomes visible at the output on the following cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wrPtr;
  logic [AW-1:0]    r_rdPtr;
  logic [AW:0]      r_count;
  logic             w_pushOk;
  logic             w_popOk;

  assign o_full   = (r_count == FULL_COUNT);
  assign o_empty  = (r_count == '0);
  assign w_pushOk = i_push & ~o_full;
  assign w_popOk  = i_pop & ~o_empty;
  assign o_dout   = r_mem[r_rdPtr];

  // Storage array: written only on an accepted push, never reset
  always_ff @(posedge clk) begin
    if (w_pushOk) begin
      r_mem[r_wrPtr] <= i_din;
    end
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_pushOk) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_popOk) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      case ({w_pushOk, w_popOk})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter sitting beside data RAM. Stores to
// TXDATA are queued in a byte FIFO and serialised on tx; loads are answered
// combinationally so a single-cycle core can read STATUS/BAUDDIV directly.
module mmio_uart_tx
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_write,
  input  logic        mem_read,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_data_to_mem,
  output logic        uart_sel,
  output logic [31:0] uart_rdata,
  output logic        tx
);

  logic [1:0]  w_offset;
  logic        w_wrEn;
  logic        w_pushReq;
  logic        w_pop;
  logic [7:0]  w_fifoDout;
  logic        w_full;
  logic        w_empty;
  logic        w_busy;
  logic [31:0] w_status;
  logic        w_unused;

  logic        r_overrun;
  logic [15:0] r_baudDiv;

  tx_state_t   r_state;
  tx_state_t   w_stateNext;
  logic [15:0] r_baudCnt;
  logic [15:0] w_baudCntNext;
  logic [2:0]  r_bitCnt;
  logic [2:0]  w_bitCntNext;
  logic [7:0]  r_shift;
  logic [7:0]  w_shiftNext;
  logic [15:0] r_divEff;
  logic [15:0] w_divEffNext;
  logic        r_tx;
  logic        w_txNext;
  logic        w_bitDone;

  // Byte lanes and low address bits that the register map does not use
  assign w_unused = &{1'b0, mem_data_to_mem[31:16], mem_address[1:0]};

  assign uart_sel  = (mem_address[31:4] == BASE_ADDR[31:4]);
  assign w_offset  = mem_address[3:2];
  assign w_wrEn    = mem_write & uart_sel;
  assign w_pushReq = w_wrEn & (w_offset == UART_TXDATA);
  assign w_busy    = (r_state != TX_IDLE);
  assign tx        = r_tx;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_pushReq),
    .i_din   (mem_data_to_mem[7:0]),
    .i_pop   (w_pop),
    .o_dout  (w_fifoDout),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Control registers: sticky overrun on a dropped push, cleared by any STATUS write
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_overrun <= 1'b0;
      r_baudDiv <= DEFAULT_DIV;
    end else begin
      if (w_pushReq && w_full) begin
        r_overrun <= 1'b1;
      end else if (w_wrEn && (w_offset == UART_STATUS)) begin
        r_overrun <= 1'b0;
      end
      if (w_wrEn && (w_offset == UART_BAUDDIV)) begin
        r_baudDiv <= mem_data_to_mem[15:0];
      end
    end
  end

  // STATUS word assembled from live state
  always_comb begin
    w_status               = '0;
    w_status[STAT_FULL]    = w_full;
    w_status[STAT_EMPTY]   = w_empty;
    w_status[STAT_BUSY]    = w_busy;
    w_status[STAT_OVERRUN] = r_overrun;
  end

  // Combinational read mux; zero unless a selected load is in progress
  always_comb begin
    uart_rdata = '0;
    if (uart_sel && mem_read) begin
      case (w_offset)
        UART_STATUS:  uart_rdata = w_status;
        UART_BAUDDIV: uart_rdata = {16'd0, r_baudDiv};
        default:      uart_rdata = '0;
      endcase
    end
  end

  assign w_bitDone = (r_baudCnt == (r_divEff - 16'd1));

  // Transmitter next-state logic; the divisor is latched at each pop so a
  // BAUDDIV change only affects the following frame
  always_comb begin
    w_stateNext   = r_state;
    w_baudCntNext = r_baudCnt;
    w_bitCntNext  = r_bitCnt;
    w_shiftNext   = r_shift;
    w_divEffNext  = r_divEff;
    w_pop         = 1'b0;
    w_txNext      = 1'b1;
    case (r_state)
      TX_IDLE: begin
        w_txNext = 1'b1;
        if (!w_empty) begin
          w_pop         = 1'b1;
          w_shiftNext   = w_fifoDout;
          w_divEffNext  = effDiv(r_baudDiv);
          w_baudCntNext = '0;
          w_bitCntNext  = '0;
          w_stateNext   = TX_START;
        end
      end
      TX_START: begin
        w_txNext = 1'b0;
        if (w_bitDone) begin
          w_baudCntNext = '0;
          w_bitCntNext  = '0;
          w_stateNext   = TX_DATA;
        end else begin
          w_baudCntNext = r_baudCnt + 16'd1;
        end
      end
      TX_DATA: begin
        w_txNext = r_shift[0];
        if (w_bitDone) begin
          w_baudCntNext = '0;
          w_shiftNext   = {1'b0, r_shift[7:1]};
          if (r_bitCnt == 3'd7) begin
            w_bitCntNext = '0;
            w_stateNext  = TX_STOP;
          end else begin
            w_bitCntNext = r_bitCnt + 3'd1;
          end
        end else begin
          w_baudCntNext = r_baudCnt + 16'd1;
        end
      end
      TX_STOP: begin
        w_txNext = 1'b1;
        if (w_bitDone) begin
          w_baudCntNext = '0;
          if (!w_empty) begin
            w_pop        = 1'b1;
            w_shiftNext  = w_fifoDout;
            w_divEffNext = effDiv(r_baudDiv);
            w_bitCntNext = '0;
            w_stateNext  = TX_START;
          end else begin
            w_stateNext = TX_IDLE;
          end
        end else begin
          w_baudCntNext = r_baudCnt + 16'd1;
        end
      end
      default: begin
        w_stateNext = TX_IDLE;
      end
    endcase
  end

  // Transmitter state register; tx is registered one cycle behind the state,
  // which puts the first start bit two edges after the push
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= TX_IDLE;
      r_baudCnt <= '0;
      r_bitCnt  <= '0;
      r_shift   <= '0;
      r_divEff  <= '0;
      r_tx      <= 1'b1;
    end else begin
      r_state   <= w_stateNext;
      r_baudCnt <= w_baudCntNext;
      r_bitCnt  <= w_bitCntNext;
      r_shift   <= w_shiftNext;
      r_divEff  <= w_divEffNext;
      r_tx      <= w_txNext;
    end
  end

endmodule
